uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Upstream command stage for led_sw_cmd. Consumes bytes from the UART receiver
//  and parses ASCII commands "H dddd" (4 decimal digits) and "L bbbbbbbbb" (9 binary digits).
//  Commits 4 ASCII digit chars to hex_ascii (drives led_sv_input[31:0]; bit 32 tied 0 at top).
//  Commits 9 LED bits to led_bits (drives led_output).
//  Returns a one-byte ACK/NAK per command to the UART transmitter via a valid/ready handshake.
// PARAMETERS
//  TIMEOUT_CYCLES  50_000_000  inter-byte timeout inside a command, in CLK cycles (>=2)
//  ACK_CHAR        8'h4B       'K', sent on a committed command
//  NAK_CHAR        8'h45       'E', sent on a rejected/aborted command
// PORTS
//  CLK         in   1   system clock; all logic rising-edge
//  RST         in   1   synchronous, active-high reset
//  rx_data     in   8   received byte; valid only with rx_valid
//  rx_valid    in   1   1-cycle strobe per byte; may assert on consecutive cycles
//  hex_ascii   out  32  4 ASCII digits; [31:24] first typed, [7:0] last typed (HEX0)
//  led_bits    out  9   LED pattern; first typed bit lands in [8]
//  cmd_update  out  1   1-cycle pulse in the cycle hex_ascii or led_bits changes
//  tx_data     out  8   response byte
//  tx_valid    out  1   response pending
//  tx_ready    in   1   transmitter accepts tx_data when tx_valid&tx_ready
//  resp_drop   out  1   1-cycle pulse: a response was lost (holding register busy)
// BEHAVIOUR
//  Reset: hex_ascii=32'h30303030 ("0000"), led_bits=0, cmd_update=0, tx_data=0,
//   tx_valid=0, resp_drop=0, state=IDLE, digit count=0, timeout count=0, shadows cleared.
//   Applies mid-command as well: partial command and pending response discarded.
//  FSM states: IDLE, HEX, LED, TERM. Case-insensitive for 'H'/'L'.
//  IDLE: CR(0D)/LF(0A)/space(20) ignored. 'H'->HEX, 'L'->LED, cnt=0. Any other byte -> NAK, stay IDLE.
//  HEX: '0'..'9' -> shadow32={shadow32[23:0],byte}, cnt++; 4th digit -> TERM.
//   Any other byte (incl. CR/LF) -> NAK, IDLE, shadow discarded.
//  LED: '0'/'1' -> shadow9={shadow9[7:0],byte[0]}, cnt++; 9th bit -> TERM. Other byte -> NAK, IDLE.
//  TERM: CR or LF -> commit shadow to hex_ascii/led_bits (per the originating command), cmd_update=1, ACK, IDLE.
//   Other byte -> NAK, IDLE, no commit.
//  Latency: outputs and response load update on the CLK edge after the rx_valid cycle (1 cycle).
//  Timeout: in HEX/LED/TERM the counter increments each cycle without rx_valid.
//   Clears on rx_valid and on entry to IDLE.
//   Reaching TIMEOUT_CYCLES -> NAK, IDLE, no commit. rx_valid in the same cycle wins (byte processed, counter cleared).
//  Response register (single entry):
//   empty -> load, tx_valid=1 next cycle;
//   full & tx_ready same cycle -> load new, tx_valid stays 1 (back-to-back);
//   full & !tx_ready -> new response dropped, resp_drop pulses, tx_data unchanged.
//   tx_data/tx_valid stable while tx_valid & !tx_ready. Accept with no new response -> tx_valid=0.
//  Parsing never stalls on tx_ready; outputs commit even if the ACK is dropped.
// STRUCTURE
//  Package uart_cmd_pkg:
//   state typedef (IDLE/HEX/LED/TERM);
//   ASCII constants CHAR_CR, CHAR_LF, CHAR_SP, CHAR_0, CHAR_9, CHAR_H, CHAR_L (upper/lower case);
//   HEX_DIGITS=4, LED_BITS=9.
//  Sub-module: cmd_resp_reg (one-entry valid/ready holding register with drop pulse).
//   FSM, shadows, counters and output registers stay in uart_cmd_parser.
// TESTING (TIMEOUT_CYCLES=16 in bench)
//  1 RST 2 cycles -> hex_ascii=32'h30303030, led_bits=0, tx_valid=0, cmd_update=0.
//  2 "H1234\r", tx_ready=1 -> hex_ascii=32'h31323334 one cycle after CR, cmd_update one pulse, tx_data=8'h4B.
//  3 "l101010101\n" -> led_bits=9'h155, one 'K'. Then "L10\n" -> 'E', led_bits stays 9'h155.
//  4 "H12x" -> 'E' after 'x', hex_ascii unchanged.
//    "Z" in IDLE -> 'E'.
//    "H12345" -> 'E' on '5'.
//  5 "H12", then 16 idle cycles -> 'E', FSM IDLE.
//    "H12", 15 idle cycles, "34\r" -> committed, 'K'.
//    Then "H5678\r" -> 32'h35363738.
//  6 tx_ready=0: "H1111\r" then "Q" -> tx_data holds 'K', resp_drop pulses on Q.
//    RST during "L10" -> all reset values, no response emitted.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and ASCII constants for the UART command parser
package uart_cmd_pkg;

  typedef enum logic [1:0] {IDLE, HEX, LED, TERM} state_t;

  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_SP   = 8'h20;
  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_1    = 8'h31;
  localparam logic [7:0] CHAR_9    = 8'h39;
  localparam logic [7:0] CHAR_H    = 8'h48;
  localparam logic [7:0] CHAR_H_LC = 8'h68;
  localparam logic [7:0] CHAR_L    = 8'h4C;
  localparam logic [7:0] CHAR_L_LC = 8'h6C;

  localparam int HEX_DIGITS = 4;
  localparam int LED_BITS   = 9;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CHAR_CR) || (b == CHAR_LF);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CHAR_0) && (b <= CHAR_9);
  endfunction

endpackage

// File: rtl/cmd_resp_reg.sv
// rtl/cmd_resp_reg.sv - one-entry valid/ready response holding register with drop pulse
module cmd_resp_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       drop
);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      drop     <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (load_valid) begin
        // An accept in the same cycle frees the slot, so back-to-back loads keep tx_valid high
        if (!tx_valid || tx_ready) begin
          tx_data  <= load_data;
          tx_valid <= 1'b1;
        end else begin
          drop <= 1'b1;
        end
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - parses "H dddd" / "L bbbbbbbbb" UART commands and returns ACK/NAK
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0] ACK_CHAR       = 8'h4B,
  parameter logic [7:0] NAK_CHAR       = 8'h45
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] hex_ascii,
  output logic [8:0]  led_bits,
  output logic        cmd_update,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        resp_drop
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   hex_sh_q, hex_sh_d, hex_d;
  logic [8:0]    led_sh_q, led_sh_d, led_d;
  logic          is_led_q, is_led_d;
  logic          upd_d;
  logic          resp_valid;
  logic [7:0]    resp_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      hex_sh_q   <= '0;
      led_sh_q   <= '0;
      is_led_q   <= 1'b0;
      hex_ascii  <= 32'h30303030;
      led_bits   <= '0;
      cmd_update <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      hex_sh_q   <= hex_sh_d;
      led_sh_q   <= led_sh_d;
      is_led_q   <= is_led_d;
      hex_ascii  <= hex_d;
      led_bits   <= led_d;
      cmd_update <= upd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    hex_sh_d   = hex_sh_q;
    led_sh_d   = led_sh_q;
    is_led_d   = is_led_q;
    hex_d      = hex_ascii;
    led_d      = led_bits;
    upd_d      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = NAK_CHAR;
    if (rx_valid) begin
      // A byte always wins over a timeout expiring in the same cycle
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (is_eol(rx_data) || rx_data == CHAR_SP) begin
            state_d = IDLE;
          end else if (rx_data == CHAR_H || rx_data == CHAR_H_LC) begin
            state_d  = HEX;
            cnt_d    = '0;
            is_led_d = 1'b0;
          end else if (rx_data == CHAR_L || rx_data == CHAR_L_LC) begin
            state_d  = LED;
            cnt_d    = '0;
            is_led_d = 1'b1;
          end else begin
            resp_valid = 1'b1;
          end
        end
        HEX: begin
          if (is_digit(rx_data)) begin
            hex_sh_d = {hex_sh_q[23:0], rx_data};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'(HEX_DIGITS - 1)) state_d = TERM;
          end else begin
            resp_valid = 1'b1;
            state_d    = IDLE;
          end
        end
        LED: begin
          if (rx_data == CHAR_0 || rx_data == CHAR_1) begin
            led_sh_d = {led_sh_q[7:0], rx_data[0]};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'(LED_BITS - 1)) state_d = TERM;
          end else begin
            resp_valid = 1'b1;
            state_d    = IDLE;
          end
        end
        TERM: begin
          resp_valid = 1'b1;
          state_d    = IDLE;
          if (is_eol(rx_data)) begin
            resp_data = ACK_CHAR;
            upd_d     = 1'b1;
            if (is_led_q) led_d = led_sh_q;
            else          hex_d = hex_sh_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        resp_valid = 1'b1;
        state_d    = IDLE;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  cmd_resp_reg u_resp (
    .clk       (CLK),
    .rst       (RST),
    .load_valid(resp_valid),
    .load_data (resp_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .drop      (resp_drop)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] hex_ascii;
  logic [8:0]  led_bits;
  logic        cmd_update;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        resp_drop;

  int n_cmp = 0;
  int n_err = 0;
  int n_upd = 0;
  int n_drop = 0;
  logic [7:0] exp_q[$];

  localparam logic [7:0] K = 8'h4B;
  localparam logic [7:0] E = 8'h45;

  uart_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .hex_ascii (hex_ascii),
    .led_bits  (led_bits),
    .cmd_update(cmd_update),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .resp_drop (resp_drop)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (cmd_update) n_upd++;
      if (resp_drop) n_drop++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected", 32'(tx_valid), 32'd0);
        else                   chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_hex", hex_ascii, 32'h30303030);
    chk("rst_led", 32'(led_bits), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_upd", 32'(cmd_update), 32'd0);
    RST = 1'b0;
    idle(2);

    exp_q.push_back(K);
    send_str("H1234");
    chk("hex_before_cr", hex_ascii, 32'h30303030);
    send_byte(8'h0D);
    chk("hex_commit", hex_ascii, 32'h31323334);
    chk("upd_pulse_hi", 32'(cmd_update), 32'd1);
    chk("ack_data", 32'(tx_data), 32'(K));
    idle(1);
    chk("upd_pulse_lo", 32'(cmd_update), 32'd0);
    idle(2);

    exp_q.push_back(K);
    send_str("l101010101");
    send_byte(8'h0A);
    chk("led_commit", 32'(led_bits), 32'h155);
    exp_q.push_back(E);
    send_str("L10");
    send_byte(8'h0A);
    chk("led_short_keep", 32'(led_bits), 32'h155);
    idle(2);

    exp_q.push_back(E);
    send_str("H12x");
    chk("hex_bad_digit", hex_ascii, 32'h31323334);
    exp_q.push_back(E);
    send_str("Z");
    idle(1);
    exp_q.push_back(E);
    send_str("H12345");
    chk("hex_extra_digit", hex_ascii, 32'h31323334);
    idle(3);

    exp_q.push_back(E);
    send_str("H12");
    idle(15);
    chk("tmo_not_yet", 32'(tx_valid), 32'd0);
    idle(1);
    chk("tmo_nak", 32'(tx_valid), 32'd1);
    exp_q.push_back(E);
    send_str("3");
    idle(2);

    exp_q.push_back(K);
    send_str("H12");
    idle(15);
    send_str("34");
    send_byte(8'h0D);
    chk("tmo_edge_commit", hex_ascii, 32'h31323334);
    exp_q.push_back(K);
    send_str("H5678");
    send_byte(8'h0D);
    chk("hex_second", hex_ascii, 32'h35363738);
    idle(3);

    tx_ready = 1'b0;
    exp_q.push_back(K);
    send_str("H1111");
    send_byte(8'h0D);
    chk("hex_no_ready", hex_ascii, 32'h31313131);
    send_str("Q");
    chk("drop_pulse", 32'(resp_drop), 32'd1);
    chk("hold_data", 32'(tx_data), 32'(K));
    chk("hold_valid", 32'(tx_valid), 32'd1);
    idle(3);
    chk("hold_data_late", 32'(tx_data), 32'(K));
    tx_ready = 1'b1;
    idle(3);

    tx_ready = 1'b0;
    send_str("Z");
    send_str("L10");
    RST = 1'b1;
    idle(2);
    chk("rst2_hex", hex_ascii, 32'h30303030);
    chk("rst2_led", 32'(led_bits), 32'd0);
    chk("rst2_txv", 32'(tx_valid), 32'd0);
    chk("rst2_upd", 32'(cmd_update), 32'd0);
    RST = 1'b0;
    tx_ready = 1'b1;
    idle(8);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("upd_count", 32'(n_upd), 32'd5);
    chk("drop_count", 32'(n_drop), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
